transfer_splitter: RTL and testbench
====================================

TRANSFER_SPLITTER -- requirements
Module: transfer_splitter

Interface
REQ-001 SHALL have ports CLK in 1, the single clock; RESET in 1, asynchronous active-high reset.
REQ-002 SHALL have REQ_VALID in 1, request offered; REQ_READY out 1, request accepted when both high at CLK rise.
REQ-003 SHALL have REQ_ADDR in 24, byte address; REQ_SIZE in 2 (0 byte, 1 word, 3 long, 2 reserved); REQ_WRITE in 1; REQ_WDATA in 32, big-endian, right-justified.
REQ-004 SHALL have ACTIVATE out 1, start pulse to bus FSM; MUST_CONTINUE out 1, more bus cycles follow the current one.
REQ-005 SHALL have LATCH_STROBE in 1, bus FSM in latch state; CYCLE_DONE in 1, bus FSM in finalize state.
REQ-006 SHALL have BUS_ADDR out 23 (A23..A1); UDS_EN out 1; LDS_EN out 1; BUS_WRITE out 1; BUS_WDATA out 16; BUS_RDATA in 16.
REQ-007 SHALL have RESP_VALID out 1, one-cycle completion pulse; RESP_RDATA out 32, right-justified read result; BUSY out 1.

Function
REQ-008 SHALL split each request into 1-3 68000 bus pieces:
  - byte: 1 piece, UDS if A0=0 else LDS
  - word, A0=0: 1 piece, both strobes
  - word, A0=1: A/LDS, then A+1/UDS
  - long, A0=0: A/both (high word), then A+2/both (low word)
  - long, A0=1: A/LDS (bits 31:24), A+1/both (23:8), A+3/UDS (7:0).
REQ-009 SHALL treat REQ_SIZE=2 exactly as word.
REQ-010 SHALL compute piece addresses modulo 2^24; 0xFFFFFF long wraps to 0x000000/0x000002.
REQ-011 SHALL use states IDLE, START, RUN, RESPOND; IDLE->START on accept; START->RUN unconditionally; RUN->RUN on CYCLE_DONE with pieces remaining; RUN->RESPOND on CYCLE_DONE of last piece; RESPOND->IDLE.
REQ-012 SHALL assert REQ_READY only in IDLE; BUSY high in every other state.
REQ-013 SHALL register address, size, direction and write data on accept; later changes on REQ_* SHALL have no effect.
REQ-014 SHALL drive ACTIVATE high for exactly the one START cycle per request, never per subsequent piece.
REQ-015 SHALL hold BUS_ADDR, UDS_EN, LDS_EN, BUS_WRITE, BUS_WDATA stable for the current piece from START until the cycle after its CYCLE_DONE.
REQ-016 SHALL drive MUST_CONTINUE high in START and RUN whenever the current piece is not the last, low otherwise.
REQ-017 SHALL advance to the next piece on the CLK edge sampling CYCLE_DONE high in RUN, so the next piece is valid before the bus FSM reaches setup.
REQ-018 SHALL place write bytes on the lane(s) of the active strobe; a single byte SHALL be replicated on both lanes.
REQ-019 SHALL capture BUS_RDATA lane(s) of the active strobe into the correct RESP_RDATA byte positions on LATCH_STROBE in RUN; unused upper bytes SHALL read 0.
REQ-020 SHALL pulse RESP_VALID one cycle in RESPOND, with RESP_RDATA valid then and held until the next accept; writes SHALL return RESP_RDATA unchanged.
REQ-021 SHALL ignore CYCLE_DONE and LATCH_STROBE outside RUN.
REQ-022 SHALL treat CYCLE_DONE held over consecutive cycles as one completion per low-to-high edge.

Reset
REQ-023 SHALL on RESET force IDLE, REQ_READY=1 after release, all other outputs 0, RESP_RDATA=0.
REQ-024 SHALL on RESET mid-request drop the request, emit no RESP_VALID, and accept fresh requests on the first edge after release.

Verification
REQ-025 Byte read 0x000011 -> 1 ACTIVATE, BUS_ADDR=0x000008, LDS only, MUST_CONTINUE=0; BUS_RDATA=0x12AB -> RESP_RDATA=0x000000AB.
REQ-026 Long write 0x001000, data 0xDEADBEEF -> pieces 0x000800 WDATA 0xDEAD, 0x000801 WDATA 0xBEEF, both strobes; MUST_CONTINUE 1 then 0; one RESP_VALID.
REQ-027 Long read 0x000003 -> pieces A 0x000001 LDS, 0x000002 both, 0x000003 UDS; reads 0x0011, 0x2233, 0x44FF -> RESP_RDATA=0x11223344.
REQ-028 Word read 0xFFFFFF -> pieces 0x7FFFFF LDS, 0x000000 UDS; BUS_RDATA 0x00AA then 0xBB00 -> RESP_RDATA=0x0000AABB.
REQ-029 RESET asserted after first CYCLE_DONE of a long write -> no RESP_VALID, outputs 0; new byte request accepted on first edge after release.
REQ-030 REQ_VALID held during a word read -> REQ_READY=0 until RESPOND exits; second request accepted only afterwards, single ACTIVATE each.

Source files
------------

// File: rtl/transfer_splitter.sv
// transfer_splitter: breaks byte/word/long requests into 68000 bus pieces,
// drives one bus FSM activation per request and assembles read data.
module transfer_splitter (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [23:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_write,
    input  logic [31:0] req_wdata,
    output logic        activate,
    output logic        must_continue,
    input  logic        latch_strobe,
    input  logic        cycle_done,
    output logic [22:0] bus_addr,
    output logic        uds_en,
    output logic        lds_en,
    output logic        bus_write,
    output logic [15:0] bus_wdata,
    input  logic [15:0] bus_rdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, START, RUN, RESPOND} state_t;

    // One bus piece: halfword address, strobes, lane data and the
    // position (in bytes, from the LSB) of its lowest data byte.
    typedef struct packed {
        logic        last;
        logic [22:0] addr;
        logic        uds;
        logic        lds;
        logic [15:0] wdata;
        logic [1:0]  lsb;
    } piece_t;

    // Piece idx of a request; size 2 falls into the word branch.
    function automatic piece_t piece_of(input logic [23:0] a, input logic [1:0] size,
                                        input logic [1:0] idx, input logic [31:0] wd);
        piece_t      p;
        logic [2:0]  nbytes;
        logic [2:0]  off;
        logic        both;
        logic [23:0] pa;
        logic [4:0]  sh;
        p = '0;
        case (size)
            2'd0: begin
                nbytes = 3'd1; off = 3'd0; both = 1'b0; p.last = 1'b1;
            end
            2'd3: begin
                nbytes = 3'd4;
                if (!a[0]) begin
                    off = (idx == 2'd0) ? 3'd0 : 3'd2; both = 1'b1; p.last = (idx != 2'd0);
                end else begin
                    case (idx)
                        2'd0:    begin off = 3'd0; both = 1'b0; p.last = 1'b0; end
                        2'd1:    begin off = 3'd1; both = 1'b1; p.last = 1'b0; end
                        default: begin off = 3'd3; both = 1'b0; p.last = 1'b1; end
                    endcase
                end
            end
            default: begin
                nbytes = 3'd2;
                if (!a[0]) begin
                    off = 3'd0; both = 1'b1; p.last = 1'b1;
                end else begin
                    off = {2'b00, idx[0]}; both = 1'b0; p.last = idx[0];
                end
            end
        endcase
        pa     = a + 24'(off);
        p.addr = pa[23:1];
        if (both) begin
            p.uds   = 1'b1;
            p.lds   = 1'b1;
            p.lsb   = 2'(nbytes - off - 3'd2);
            sh      = {p.lsb, 3'b000};
            p.wdata = 16'(wd >> sh);
        end else begin
            p.uds   = ~pa[0];
            p.lds   = pa[0];
            p.lsb   = 2'(nbytes - off - 3'd1);
            sh      = {p.lsb, 3'b000};
            p.wdata = {2{8'(wd >> sh)}};
        end
        return p;
    endfunction

    state_t      state;
    logic [23:0] addr_q;
    logic [1:0]  size_q;
    logic [31:0] wdata_q;
    logic [1:0]  idx;
    logic [1:0]  cur_lsb;
    logic        cycle_done_q;
    logic        done_edge;
    piece_t      piece_first;
    piece_t      piece_next;
    logic [4:0]  cap_shift;
    logic [31:0] cap_mask;
    logic [31:0] cap_data;

    assign piece_first = piece_of(req_addr, req_size, 2'd0, req_wdata);
    assign piece_next  = piece_of(addr_q, size_q, idx + 2'd1, wdata_q);
    assign done_edge   = cycle_done & ~cycle_done_q;

    // Read lane(s) of the active strobe placed at the piece's byte position.
    always_comb begin
        cap_mask  = '0;
        cap_data  = '0;
        cap_shift = {cur_lsb, 3'b000};
        if (uds_en && lds_en) begin
            cap_mask = 32'h0000_FFFF << cap_shift;
            cap_data = {16'h0000, bus_rdata} << cap_shift;
        end else begin
            cap_mask = 32'h0000_00FF << cap_shift;
            cap_data = {24'h00_0000, (uds_en ? bus_rdata[15:8] : bus_rdata[7:0])} << cap_shift;
        end
    end

    // Request FSM with registered bus and response outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            req_ready     <= 1'b1;
            busy          <= 1'b0;
            activate      <= 1'b0;
            must_continue <= 1'b0;
            bus_addr      <= '0;
            uds_en        <= 1'b0;
            lds_en        <= 1'b0;
            bus_write     <= 1'b0;
            bus_wdata     <= '0;
            resp_valid    <= 1'b0;
            resp_rdata    <= '0;
            addr_q        <= '0;
            size_q        <= '0;
            wdata_q       <= '0;
            idx           <= '0;
            cur_lsb       <= '0;
            cycle_done_q  <= 1'b0;
        end else begin
            cycle_done_q <= cycle_done;
            activate     <= 1'b0;
            resp_valid   <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q        <= req_addr;
                        size_q        <= req_size;
                        wdata_q       <= req_wdata;
                        idx           <= 2'd0;
                        bus_addr      <= piece_first.addr;
                        uds_en        <= piece_first.uds;
                        lds_en        <= piece_first.lds;
                        bus_wdata     <= piece_first.wdata;
                        cur_lsb       <= piece_first.lsb;
                        must_continue <= ~piece_first.last;
                        bus_write     <= req_write;
                        if (!req_write) begin
                            resp_rdata <= '0;
                        end
                        activate  <= 1'b1;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= START;
                    end
                end
                START: begin
                    state <= RUN;
                end
                RUN: begin
                    if (latch_strobe && !bus_write) begin
                        resp_rdata <= (resp_rdata & ~cap_mask) | cap_data;
                    end
                    if (done_edge) begin
                        if (must_continue) begin
                            idx           <= idx + 2'd1;
                            bus_addr      <= piece_next.addr;
                            uds_en        <= piece_next.uds;
                            lds_en        <= piece_next.lds;
                            bus_wdata     <= piece_next.wdata;
                            cur_lsb       <= piece_next.lsb;
                            must_continue <= ~piece_next.last;
                        end else begin
                            resp_valid <= 1'b1;
                            state      <= RESPOND;
                        end
                    end
                end
                RESPOND: begin
                    bus_addr  <= '0;
                    uds_en    <= 1'b0;
                    lds_en    <= 1'b0;
                    bus_write <= 1'b0;
                    bus_wdata <= '0;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_transfer_splitter.sv
// tb_transfer_splitter: directed requests against a byte-level model of the
// 68000 piece split, checked by a per-cycle compare process.
module tb_transfer_splitter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [23:0] req_addr;
    logic [1:0]  req_size;
    logic        req_write;
    logic [31:0] req_wdata;
    logic        activate;
    logic        must_continue;
    logic        latch_strobe;
    logic        cycle_done;
    logic [22:0] bus_addr;
    logic        uds_en;
    logic        lds_en;
    logic        bus_write;
    logic [15:0] bus_wdata;
    logic [15:0] bus_rdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        busy;

    transfer_splitter dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_size(req_size), .req_write(req_write), .req_wdata(req_wdata),
        .activate(activate), .must_continue(must_continue),
        .latch_strobe(latch_strobe), .cycle_done(cycle_done),
        .bus_addr(bus_addr), .uds_en(uds_en), .lds_en(lds_en), .bus_write(bus_write),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int act_cnt = 0;
    int act_exp = 0;

    // expected outputs for the current cycle
    logic        mon_en = 1'b0;
    logic        e_ready, e_busy, e_act, e_mc, e_rv, e_chk_bus, e_chk_rd;
    logic        e_uds, e_lds, e_write;
    logic [22:0] e_addr;
    logic [15:0] e_wdata;
    logic [31:0] e_rdata;

    // model state: request bytes grouped into halfword pieces
    int          np;
    int          nbytes;
    int          grp[4];
    logic [22:0] p_addr[3];
    logic        p_uds[3];
    logic        p_lds[3];
    logic [15:0] p_wd[3];
    logic [31:0] m_rdata = '0;
    logic        cur_write;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Compare DUT outputs with the expectation every cycle.
    always @(negedge clk) begin
        if (activate === 1'b1) act_cnt++;
        if (mon_en) begin
            chk("req_ready",     32'(req_ready),     32'(e_ready));
            chk("busy",          32'(busy),          32'(e_busy));
            chk("activate",      32'(activate),      32'(e_act));
            chk("must_continue", 32'(must_continue), 32'(e_mc));
            chk("resp_valid",    32'(resp_valid),    32'(e_rv));
            if (e_chk_bus) begin
                chk("bus_addr",  32'(bus_addr),  32'(e_addr));
                chk("uds_en",    32'(uds_en),    32'(e_uds));
                chk("lds_en",    32'(lds_en),    32'(e_lds));
                chk("bus_write", 32'(bus_write), 32'(e_write));
                chk("bus_wdata", 32'(bus_wdata), 32'(e_wdata));
            end
            if (e_chk_rd) chk("resp_rdata", resp_rdata, e_rdata);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Byte at A+i is data byte (n-1-i); bytes sharing a halfword form one piece.
    task automatic build(input logic [23:0] a, input logic [1:0] sz, input logic [31:0] wd);
        logic [23:0] b;
        logic [7:0]  d;
        int          k;
        nbytes = (sz == 2'd0) ? 1 : ((sz == 2'd3) ? 4 : 2);
        np = 0;
        for (int i = 0; i < nbytes; i++) begin
            b = a + 24'(i);
            d = 8'(wd >> (8 * (nbytes - 1 - i)));
            if (np == 0 || p_addr[np-1] != b[23:1]) begin
                p_addr[np] = b[23:1];
                p_uds[np]  = 1'b0;
                p_lds[np]  = 1'b0;
                p_wd[np]   = '0;
                np++;
            end
            k = np - 1;
            grp[i] = k;
            if (!b[0]) begin
                p_uds[k] = 1'b1;
                p_wd[k][15:8] = d;
            end else begin
                p_lds[k] = 1'b1;
                p_wd[k][7:0] = d;
            end
        end
        for (int j = 0; j < np; j++) begin
            if (p_uds[j] && !p_lds[j]) p_wd[j][7:0]  = p_wd[j][15:8];
            if (!p_uds[j] && p_lds[j]) p_wd[j][15:8] = p_wd[j][7:0];
        end
    endtask

    task automatic set_piece_exp(input int k);
        e_chk_bus = 1'b1;
        e_addr    = p_addr[k];
        e_uds     = p_uds[k];
        e_lds     = p_lds[k];
        e_wdata   = p_wd[k];
        e_write   = cur_write;
        e_mc      = (k < np - 1);
    endtask

    task automatic set_idle_exp();
        e_ready   = 1'b1;
        e_busy    = 1'b0;
        e_act     = 1'b0;
        e_mc      = 1'b0;
        e_rv      = 1'b0;
        e_chk_bus = 1'b0;
        e_chk_rd  = 1'b1;
        e_rdata   = m_rdata;
    endtask

    task automatic set_reset_exp();
        m_rdata = '0;
        set_idle_exp();
        e_chk_bus = 1'b1;
        e_addr    = '0;
        e_uds     = 1'b0;
        e_lds     = 1'b0;
        e_write   = 1'b0;
        e_wdata   = '0;
    endtask

    // Issue one request and play the bus FSM for each piece.
    task automatic do_req(input logic [23:0] a, input logic [1:0] sz, input logic wr,
                          input logic [31:0] wd, input logic [15:0] r0, input logic [15:0] r1,
                          input logic [15:0] r2, input bit hold, input bit keep,
                          input int abort_at, input logic [31:0] lit);
        logic [15:0] rd[3];
        logic [31:0] exp_r;
        logic [23:0] b;
        logic [7:0]  byt;
        rd[0] = r0; rd[1] = r1; rd[2] = r2;
        build(a, sz, wd);
        exp_r = '0;
        for (int i = 0; i < nbytes; i++) begin
            b = a + 24'(i);
            byt = b[0] ? rd[grp[i]][7:0] : rd[grp[i]][15:8];
            exp_r = exp_r | (32'(byt) << (8 * (nbytes - 1 - i)));
        end
        if (wr) exp_r = m_rdata;

        cycle_done = 1'b0; latch_strobe = 1'b0;
        req_addr = a; req_size = sz; req_write = wr; req_wdata = wd; req_valid = 1'b1;
        tick();
        act_exp++;
        cur_write = wr;
        e_ready = 1'b0; e_busy = 1'b1; e_act = 1'b1; e_rv = 1'b0; e_chk_rd = 1'b1;
        if (!wr) m_rdata = '0;
        e_rdata = m_rdata;
        set_piece_exp(0);
        if (!keep) begin
            req_valid = 1'b0; req_addr = ~a; req_size = ~sz; req_write = ~wr; req_wdata = ~wd;
        end
        tick();
        e_act = 1'b0; e_chk_rd = 1'b0;
        for (int k = 0; k < np; k++) begin
            latch_strobe = 1'b1; bus_rdata = rd[k];
            tick();
            latch_strobe = 1'b0; cycle_done = 1'b0; bus_rdata = 16'($urandom);
            tick();
            cycle_done = 1'b1;
            tick();
            if (k == abort_at) begin
                reset = 1'b1; cycle_done = 1'b0;
                set_reset_exp();
                tick();
                tick();
                reset = 1'b0;
                return;
            end
            if (k < np - 1) begin
                set_piece_exp(k + 1);
            end else begin
                e_chk_bus = 1'b0; e_mc = 1'b0; e_rv = 1'b1;
                m_rdata = exp_r; e_rdata = m_rdata; e_chk_rd = 1'b1;
            end
            if (!hold) cycle_done = 1'b0;
        end
        chk("lit_rdata", resp_rdata, lit);
        tick();
        cycle_done = 1'b0; req_valid = 1'b0;
        set_idle_exp();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        req_valid = 1'b0; req_addr = '0; req_size = '0; req_write = 1'b0; req_wdata = '0;
        latch_strobe = 1'b0; cycle_done = 1'b0; bus_rdata = '0; cur_write = 1'b0;
        set_reset_exp();
        mon_en = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();

        // model pins against hand-computed pieces
        build(24'h000011, 2'd0, 32'h0);
        chk("pin25_np", 32'(np), 32'd1);
        chk("pin25_addr", 32'(p_addr[0]), 32'h000008);
        chk("pin25_strb", 32'({p_uds[0], p_lds[0]}), 32'b01);
        build(24'h001000, 2'd3, 32'hDEADBEEF);
        chk("pin26_np", 32'(np), 32'd2);
        chk("pin26_a1", 32'(p_addr[1]), 32'h000801);
        chk("pin26_wd0", 32'(p_wd[0]), 32'h0000DEAD);
        build(24'h000003, 2'd3, 32'h0);
        chk("pin27_np", 32'(np), 32'd3);
        chk("pin27_a2", 32'(p_addr[2]), 32'h000003);
        build(24'hFFFFFF, 2'd1, 32'h0);
        chk("pin28_a0", 32'(p_addr[0]), 32'h7FFFFF);
        chk("pin28_a1", 32'(p_addr[1]), 32'h000000);

        do_req(24'h000011, 2'd0, 1'b0, 32'h0, 16'h12AB, 16'h0, 16'h0, 1'b0, 1'b0, -1, 32'h000000AB);

        // strobes outside RUN must do nothing
        cycle_done = 1'b1; latch_strobe = 1'b1; bus_rdata = 16'hFFFF;
        tick();
        tick();
        cycle_done = 1'b0; latch_strobe = 1'b0;
        tick();

        do_req(24'h001000, 2'd3, 1'b1, 32'hDEADBEEF, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, -1, 32'h000000AB);
        do_req(24'h000003, 2'd3, 1'b0, 32'h0, 16'h0011, 16'h2233, 16'h44FF, 1'b1, 1'b0, -1, 32'h11223344);
        do_req(24'hFFFFFF, 2'd1, 1'b0, 32'h0, 16'h00AA, 16'hBB00, 16'h0, 1'b0, 1'b0, -1, 32'h0000AABB);
        do_req(24'h000100, 2'd2, 1'b0, 32'h0, 16'h1234, 16'h0, 16'h0, 1'b0, 1'b0, -1, 32'h00001234);
        do_req(24'h000201, 2'd1, 1'b1, 32'h0000CAFE, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, -1, 32'h00001234);
        do_req(24'h000020, 2'd0, 1'b1, 32'h00000077, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, -1, 32'h00001234);
        do_req(24'hFFFFFF, 2'd3, 1'b1, 32'h01020304, 16'h0, 16'h0, 16'h0, 1'b1, 1'b0, -1, 32'h00001234);
        do_req(24'h000005, 2'd0, 1'b0, 32'h0, 16'h3456, 16'h0, 16'h0, 1'b0, 1'b0, -1, 32'h00000056);

        // reset in the middle of a long write, then an immediate new request
        do_req(24'h001000, 2'd3, 1'b1, 32'hDEADBEEF, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 0, 32'h0);
        do_req(24'h000002, 2'd0, 1'b0, 32'h0, 16'h9900, 16'h0, 16'h0, 1'b0, 1'b0, -1, 32'h00000099);

        // request valid held through a word read, next request right after
        do_req(24'h000040, 2'd1, 1'b0, 32'h0, 16'hBEEF, 16'h0, 16'h0, 1'b0, 1'b1, -1, 32'h0000BEEF);
        do_req(24'h000041, 2'd0, 1'b0, 32'h0, 16'h0042, 16'h0, 16'h0, 1'b0, 1'b0, -1, 32'h00000042);

        tick();
        tick();
        chk("activate_count", 32'(act_cnt), 32'(act_exp));
        chk("activate_total", 32'(act_cnt), 32'd13);
        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
